// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, fixed-latency 64-bit RAM between
// the fetch unit (read-only) and the memory stage (read/write). A fixed-priority
// arbiter favours the memory stage, and a starvation counter guarantees fetch
// progress. Out-of-range accesses are answered without touching the RAM.
module mem_port_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int RAM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [63:0]       f_addr,
  output logic              f_done,
  output logic [63:0]       f_rdata,
  output logic              f_err,
  input  logic              m_req,
  input  logic              m_we,
  input  logic [63:0]       m_addr,
  input  logic [63:0]       m_wdata,
  output logic              m_done,
  output logic [63:0]       m_rdata,
  output logic              m_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [63:0]       ram_wdata,
  input  logic [63:0]       ram_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    ERR   = 3'd4
  } state_t;

  // Highest legal start address of an 8-byte access; compared on all 64 bits.
  localparam logic [63:0] ADDR_LIMIT = (64'd1 << ADDR_W) - 64'd8;
  localparam logic [2:0]  WAIT_LAST  = 3'(RAM_LAT - 1);
  localparam logic [3:0]  STARVE_TOP = 4'(STARVE_MAX);

  state_t      state_r, state_s;
  logic [2:0]  wait_cnt_r;
  logic [3:0]  starve_r, starve_s;
  logic        win_f_r;      // latched winner: 1 = fetch
  logic        we_r;         // latched write flag of the winner

  logic        any_req_s, grant_f_s, sel_err_s, sel_we_s, wait_last_s;
  logic [63:0] sel_addr_s;
  logic        issue_go_s, err_go_s, resp_go_s;
  logic        f_done_s, m_done_s;
  logic [63:0] rd_s;

  // Arbitration and range check on the live request inputs (used in IDLE only).
  always_comb begin
    any_req_s   = f_req | m_req;
    grant_f_s   = f_req & (~m_req | (starve_r == STARVE_TOP));
    sel_addr_s  = grant_f_s ? f_addr : m_addr;
    sel_err_s   = (sel_addr_s > ADDR_LIMIT);
    sel_we_s    = ~grant_f_s & m_we;
    wait_last_s = (wait_cnt_r == WAIT_LAST);
  end

  // Next-state and starvation-counter update.
  always_comb begin
    state_s  = state_r;
    starve_s = starve_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_s = sel_err_s ? ERR : ISSUE;
          if (grant_f_s) begin
            starve_s = 4'd0;
          end else if (f_req && (starve_r != STARVE_TOP)) begin
            starve_s = starve_r + 4'd1;
          end else begin
            starve_s = starve_r;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: state_s = WAIT;
      WAIT: begin
        if (wait_last_s) begin
          state_s = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      RESP:    state_s = IDLE;
      ERR:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the transition taken.
  always_comb begin
    issue_go_s = (state_r == IDLE) & any_req_s & ~sel_err_s;
    err_go_s   = (state_r == IDLE) & any_req_s & sel_err_s;
    resp_go_s  = (state_r == WAIT) & wait_last_s;
    f_done_s   = (resp_go_s & win_f_r) | (err_go_s & grant_f_s);
    m_done_s   = (resp_go_s & ~win_f_r) | (err_go_s & ~grant_f_s);
    if (resp_go_s && !we_r) begin
      rd_s = ram_rdata;
    end else begin
      rd_s = 64'd0;
    end
  end

  // FSM state, starvation counter, wait counter and latched transaction info.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      starve_r   <= 4'd0;
      wait_cnt_r <= 3'd0;
      win_f_r    <= 1'b0;
      we_r       <= 1'b0;
    end else begin
      state_r  <= state_s;
      starve_r <= starve_s;
      if (state_r == ISSUE) begin
        wait_cnt_r <= 3'd0;
      end else if (state_r == WAIT) begin
        wait_cnt_r <= wait_cnt_r + 3'd1;
      end
      if ((state_r == IDLE) && any_req_s) begin
        win_f_r <= grant_f_s;
        we_r    <= sel_we_s;
      end
    end
  end

  // Registered RAM strobe and requester responses; data and err are zero unless done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= {ADDR_W{1'b0}};
      ram_wdata <= 64'd0;
      f_done    <= 1'b0;
      f_rdata   <= 64'd0;
      f_err     <= 1'b0;
      m_done    <= 1'b0;
      m_rdata   <= 64'd0;
      m_err     <= 1'b0;
    end else begin
      ram_en    <= issue_go_s;
      ram_we    <= issue_go_s & sel_we_s;
      ram_addr  <= issue_go_s ? sel_addr_s[ADDR_W-1:0] : {ADDR_W{1'b0}};
      ram_wdata <= (issue_go_s && sel_we_s) ? m_wdata : 64'd0;
      f_done    <= f_done_s;
      f_err     <= err_go_s & grant_f_s;
      f_rdata   <= (resp_go_s && win_f_r) ? rd_s : 64'd0;
      m_done    <= m_done_s;
      m_err     <= err_go_s & ~grant_f_s;
      m_rdata   <= (resp_go_s && !win_f_r) ? rd_s : 64'd0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int RAM_LAT  = 2;
  localparam int STARVE   = 4;
  localparam int RAND_CYC = 600;
  localparam logic [63:0] LIMIT = 64'd2040;

  logic        clk, rst_n;
  logic        f_req, f_done, f_err;
  logic [63:0] f_addr, f_rdata;
  logic        m_req, m_we, m_done, m_err;
  logic [63:0] m_addr, m_wdata, m_rdata;
  logic        ram_en, ram_we;
  logic [10:0] ram_addr;
  logic [63:0] ram_wdata, ram_rdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(11), .RAM_LAT(RAM_LAT), .STARVE_MAX(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata), .f_err(f_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_done(m_done), .m_rdata(m_rdata), .m_err(m_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Default contents of never-written RAM locations.
  function automatic logic [63:0] pat(input logic [10:0] a);
    return {32'h5EED_0000 | {21'd0, a}, 32'hFFFF_FFFF ^ {21'd0, a}};
  endfunction

  // RAM environment model with RAM_LAT read latency; garbage outside the valid cycle.
  logic [63:0] mem [2048];
  bit          wr  [2048];
  bit          pv  [RAM_LAT];
  logic [63:0] pd  [RAM_LAT];
  always @(posedge clk) begin
    if (ram_en && ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wr[ram_addr]  <= 1'b1;
    end
    pv[0] <= ram_en && !ram_we;
    pd[0] <= wr[ram_addr] ? mem[ram_addr] : pat(ram_addr);
    for (int i = 1; i < RAM_LAT; i++) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
  end
  assign ram_rdata = pv[RAM_LAT-1] ? pd[RAM_LAT-1] : 64'hBAD0_BAD0_BAD0_BAD0;

  // Reference memory contents as the requesters should see them.
  logic [63:0] ref_mem [2048];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=done", nm);
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_f_done"}, {63'd0, f_done}, 64'd0);
    chk({nm, "_m_done"}, {63'd0, m_done}, 64'd0);
    chk({nm, "_ram_en"}, {63'd0, ram_en}, 64'd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctl"}, {58'd0, f_done, f_err, m_done, m_err, ram_en, ram_we}, 64'd0);
    chk({nm, "_f_rdata"}, f_rdata, 64'd0);
    chk({nm, "_m_rdata"}, m_rdata, 64'd0);
    chk({nm, "_ram_addr"}, {53'd0, ram_addr}, 64'd0);
    chk({nm, "_ram_wdata"}, ram_wdata, 64'd0);
  endtask

  // One isolated transaction; starts at a cycle where the DUT is IDLE.
  task automatic do_txn(input bit is_f, input bit we, input logic [63:0] addr,
                        input logic [63:0] wd, input bit exp_err,
                        input logic [63:0] exp_rd, input string nm);
    int  lat, en_cnt;
    bit  got;
    lat = exp_err ? 1 : RAM_LAT + 2;
    if (is_f) begin
      f_req = 1'b1; f_addr = addr;
    end else begin
      m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wd;
    end
    got = 1'b0;
    en_cnt = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(posedge clk); #1;
      if (ram_en) begin
        en_cnt++;
        chk({nm, "_ram_we"}, {63'd0, ram_we}, {63'd0, we});
        chk({nm, "_ram_addr"}, {53'd0, ram_addr}, {53'd0, addr[10:0]});
        if (we) chk({nm, "_ram_wdata"}, ram_wdata, wd);
      end
      chk({nm, "_loser_done"}, {63'd0, (is_f ? m_done : f_done)}, 64'd0);
      if (is_f ? f_done : m_done) begin
        got = 1'b1;
        chk({nm, "_latency"}, 64'(c), 64'(lat));
        chk({nm, "_err"}, {63'd0, (is_f ? f_err : m_err)}, {63'd0, exp_err});
        chk({nm, "_rdata"}, (is_f ? f_rdata : m_rdata), exp_rd);
      end
    end
    if (!got) fail_now({nm, "_done"});
    chk({nm, "_ram_en_count"}, 64'(en_cnt), exp_err ? 64'd0 : 64'd1);
    f_req = 1'b0;
    m_req = 1'b0;
    if (we && !exp_err) ref_mem[addr[10:0]] = wd;
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, {62'd0, f_done, m_done}, 64'd0);
  endtask

  typedef struct {
    bit          is_f;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wd;
    bit          err;
    logic [63:0] rd;
  } vec_t;

  // Randomized address mix biased toward the range boundary.
  function automatic logic [63:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return {32'($urandom), 32'($urandom)};
      1:       return 64'd2036 + 64'($urandom_range(0, 11));
      default: return 64'($urandom_range(0, 2040));
    endcase
  endfunction

  initial begin
    vec_t tbl[10];
    bit   exp_ord[10];
    int   idx, dcnt, ecnt, dcyc;
    // transaction-level reference model state
    int   free_at, starve, exp_done_cyc, exp_issue_cyc;
    bit   exp_f, exp_we, exp_err, gf, f_pend, m_pend;
    logic [63:0] exp_rdata, exp_wdata, a;
    logic [10:0] exp_addr;

    tbl[0] = '{1'b0, 1'b1, 64'd5,    64'd20,     1'b0, 64'd0};
    tbl[1] = '{1'b0, 1'b0, 64'd5,    64'd0,      1'b0, 64'd20};
    tbl[2] = '{1'b0, 1'b0, 64'd2041, 64'd0,      1'b1, 64'd0};
    tbl[3] = '{1'b0, 1'b1, 64'd2040, 64'h1234,   1'b0, 64'd0};
    tbl[4] = '{1'b0, 1'b0, 64'd2040, 64'd0,      1'b0, 64'h1234};
    tbl[5] = '{1'b1, 1'b0, 64'd5,    64'd0,      1'b0, 64'd20};
    tbl[6] = '{1'b0, 1'b1, 64'h1_0000_0005, 64'd7, 1'b1, 64'd0};
    tbl[7] = '{1'b1, 1'b0, 64'd2048, 64'd0,      1'b1, 64'd0};
    tbl[8] = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0};
    tbl[9] = '{1'b0, 1'b1, 64'd30,   64'hCAFE,   1'b0, 64'd0};

    for (int i = 0; i < 2048; i++) ref_mem[i] = pat(11'(i));

    // Reset state with busy inputs
    rst_n = 1'b0;
    f_req = 1'b1; f_addr = 64'd8; m_req = 1'b1; m_we = 1'b1; m_addr = 64'd16; m_wdata = 64'd99;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    f_req = 1'b0; m_req = 1'b0; m_we = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_quiet("post_reset_idle");

    // Directed vector table
    for (int i = 0; i < 10; i++)
      do_txn(tbl[i].is_f, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].err, tbl[i].rd,
             $sformatf("vec%0d", i));

    // Both requesters held: M,M,M,M,F repeating
    exp_ord = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    f_req = 1'b1; f_addr = 64'd30; m_req = 1'b1; m_we = 1'b0; m_addr = 64'd100;
    idx = 0;
    for (int c = 0; c < 200 && idx < 10; c++) begin
      @(posedge clk); #1;
      chk("starve_both_done", {63'd0, f_done & m_done}, 64'd0);
      if (f_done || m_done) begin
        chk($sformatf("starve_order%0d", idx), {63'd0, f_done}, {63'd0, exp_ord[idx]});
        if (f_done) chk("starve_f_rdata", f_rdata, 64'hCAFE);
        else        chk("starve_m_rdata", m_rdata, ref_mem[100]);
        idx++;
        if (idx == 10) begin
          f_req = 1'b0; m_req = 1'b0;
        end
      end
    end
    if (idx < 10) fail_now("starve_sequence");
    f_req = 1'b0; m_req = 1'b0;
    @(posedge clk); #1;

    // Reset during ISSUE (k+1) and during WAIT (k+2) of a read
    for (int r = 1; r <= 2; r++) begin
      m_req = 1'b1; m_we = 1'b0; m_addr = 64'd5;
      repeat (r) @(posedge clk);
      #1;
      if (r == 1) chk("rst_issue_ram_en", {63'd0, ram_en}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk_all_zero($sformatf("rst_mid%0d", r));
      m_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
        @(posedge clk); #1;
        chk_quiet($sformatf("rst_mid%0d_after", r));
      end
      do_txn(1'b0, 1'b0, 64'd5, 64'd0, 1'b0, 64'd20, $sformatf("rst_mid%0d_new", r));
    end

    // Request dropped one cycle after grant
    m_req = 1'b1; m_we = 1'b0; m_addr = 64'd2040;
    dcnt = 0; ecnt = 0; dcyc = 0;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      if (c == 1) m_req = 1'b0;
      if (ram_en) ecnt++;
      chk("drop_f_done", {63'd0, f_done}, 64'd0);
      if (m_done) begin
        dcnt++;
        dcyc = c;
        chk("drop_rdata", m_rdata, 64'h1234);
      end
    end
    chk("drop_done_count", 64'(dcnt), 64'd1);
    chk("drop_done_cycle", 64'(dcyc), 64'(RAM_LAT + 2));
    chk("drop_ram_en_count", 64'(ecnt), 64'd1);

    // Randomized traffic against the transaction-level model
    free_at = 0; starve = 0; exp_done_cyc = -1; exp_issue_cyc = -1;
    exp_f = 1'b0; exp_we = 1'b0; exp_err = 1'b0; exp_rdata = 64'd0; exp_wdata = 64'd0;
    exp_addr = 11'd0; f_pend = 1'b0; m_pend = 1'b0;
    for (int n = 0; n < RAND_CYC + 40; n++) begin
      chk("rnd_ram_en", {63'd0, ram_en}, {63'd0, n == exp_issue_cyc});
      if (n == exp_issue_cyc) begin
        chk("rnd_ram_we", {63'd0, ram_we}, {63'd0, exp_we});
        chk("rnd_ram_addr", {53'd0, ram_addr}, {53'd0, exp_addr});
        if (exp_we) chk("rnd_ram_wdata", ram_wdata, exp_wdata);
      end
      chk("rnd_f_done", {63'd0, f_done}, {63'd0, (n == exp_done_cyc) && exp_f});
      chk("rnd_m_done", {63'd0, m_done}, {63'd0, (n == exp_done_cyc) && !exp_f});
      chk("rnd_f_err", {63'd0, f_err}, {63'd0, (n == exp_done_cyc) && exp_f && exp_err});
      chk("rnd_m_err", {63'd0, m_err}, {63'd0, (n == exp_done_cyc) && !exp_f && exp_err});
      chk("rnd_f_rdata", f_rdata, ((n == exp_done_cyc) && exp_f) ? exp_rdata : 64'd0);
      chk("rnd_m_rdata", m_rdata, ((n == exp_done_cyc) && !exp_f) ? exp_rdata : 64'd0);
      if (n == exp_done_cyc) begin
        if (exp_f) f_pend = 1'b0;
        else       m_pend = 1'b0;
      end
      if (!f_pend && n < RAND_CYC && $urandom_range(0, 2) == 0) begin
        f_pend = 1'b1; f_addr = rand_addr();
      end
      if (!m_pend && n < RAND_CYC && $urandom_range(0, 2) != 0) begin
        m_pend = 1'b1; m_addr = rand_addr(); m_we = 1'($urandom_range(0, 1));
        m_wdata = {32'($urandom), 32'($urandom)};
      end
      f_req = f_pend;
      m_req = m_pend;
      if (n >= free_at && (f_req || m_req)) begin
        gf = f_req && (!m_req || starve == STARVE);
        if (gf) starve = 0;
        else if (f_req && m_req && starve < STARVE) starve = starve + 1;
        a = gf ? f_addr : m_addr;
        exp_f = gf;
        exp_we = !gf && m_we;
        exp_err = (a > LIMIT);
        if (exp_err) begin
          exp_done_cyc = n + 1;
          exp_issue_cyc = -1;
          exp_rdata = 64'd0;
        end else begin
          exp_issue_cyc = n + 1;
          exp_done_cyc = n + RAM_LAT + 2;
          exp_addr = a[10:0];
          exp_wdata = m_wdata;
          exp_rdata = exp_we ? 64'd0 : ref_mem[a[10:0]];
          if (exp_we) ref_mem[a[10:0]] = m_wdata;
        end
        free_at = exp_done_cyc + 1;
      end
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound in case the stimulus itself stalls.
  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency 64-bit data RAM between two requesters: the fetch unit (read-only) and the memory stage (read/write for rmmovq, mrmovq, pushq, popq, call and ret).
- Contains a small transaction FSM, a fixed-priority arbiter with a starvation guard, and address-range checking.
- Returns a per-requester done pulse, read data and an error flag. The memory stage maps the error flag to dmem_error / stat ADR.

Parameters:
- ADDR_W, 11, byte-address width of the RAM. Depth is 2**ADDR_W bytes.
- RAM_LAT, 2, cycles from the ram_en cycle to valid ram_rdata. Legal range 1..7.
- STARVE_MAX, 4, consecutive fetch losses after which fetch wins the next arbitration. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- f_req  in  1  fetch read request. Held high until f_done.
- f_addr  in  64  fetch byte address.
- f_done  out  1  one-cycle completion pulse to fetch.
- f_rdata  out  64  fetch read data. Valid while f_done=1.
- f_err  out  1  fetch address error. Valid while f_done=1.
- m_req  in  1  memory-stage request. Held high until m_done.
- m_we  in  1  1 = write, 0 = read. Sampled at grant.
- m_addr  in  64  memory-stage byte address (valE or valA).
- m_wdata  in  64  write data. Sampled at grant.
- m_done  out  1  one-cycle completion pulse to the memory stage.
- m_rdata  out  64  read data (valM). Valid while m_done=1.
- m_err  out  1  memory-stage address error. Valid while m_done=1.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM byte address.
- ram_wdata  out  64  RAM write data.
- ram_rdata  in  64  RAM read data.

Behaviour:
- Reset (asynchronous on rst_n=0):
  - FSM goes to IDLE; starvation counter = 0.
  - All outputs are 0.
  - Reset asserted mid-transaction aborts it: no done pulse is produced and ram_en drops immediately.
- FSM states and transitions:
  - IDLE: if any request is high, arbitrate, latch the winner, its address and (for memory) m_we/m_wdata. Go to ERR if the address is out of range, else ISSUE.
  - ISSUE: exactly one cycle with ram_en=1, ram_we=latched we, ram_addr = latched address [ADDR_W-1:0], ram_wdata = latched data. Then go to WAIT.
  - WAIT: RAM_LAT cycles. ram_rdata is captured at the end of the final WAIT cycle. Then go to RESP.
  - RESP: one cycle. The winner's done=1 and rdata = captured data; for writes, rdata = 0. Then go to IDLE.
  - ERR: one cycle. The winner's done=1, err=1, rdata=0. No RAM access occurs. Then go to IDLE.
- Latency: a request sampled in IDLE at cycle k produces done at cycle k+RAM_LAT+2. An error produces done at cycle k+1.
- Range check: error when addr > 2**ADDR_W - 8, i.e. an 8-byte access would overrun memory. This includes any address with bits [63:ADDR_W] nonzero. The check is computed on the full 64-bit value with no wrap-around.
- Arbitration (IDLE only):
  - The memory stage wins by default.
  - Fetch wins if only f_req is high, or if starve_cnt == STARVE_MAX.
  - starve_cnt increments when both requests are high and the memory stage wins. It saturates at STARVE_MAX.
  - starve_cnt clears whenever fetch is granted.
- Handshake rules:
  - Requests are sampled only in IDLE. Requests and inputs seen in other states are ignored.
  - Dropping req before done does not cancel the transaction; done still pulses.
  - A requester holding req high through done is re-sampled in the IDLE cycle after RESP/ERR, giving back-to-back transactions one IDLE cycle apart.
  - The loser's done and err stay 0 throughout.
  - f_done and m_done are never high in the same cycle.
- Outputs are registered. rdata and err are 0 whenever the corresponding done is 0.

Test Plan:
- Reset, then m_req=1, m_we=1, m_addr=5, m_wdata=20 -> ISSUE cycle shows ram_en=1, ram_we=1, ram_addr=5, ram_wdata=20; m_done pulses at k+4 with m_err=0.
- m_req=1, m_we=0, m_addr=5, RAM model returning stored data -> m_done at k+4 with m_rdata=20 (popq/ret valM path).
- Out of range: m_addr=2041 (2048-7) -> m_done at k+1, m_err=1, m_rdata=0, ram_en never asserted. Also m_addr=2040 -> normal access with m_err=0.
- f_req and m_req both held high continuously, STARVE_MAX=4 -> grant order M,M,M,M,F,M,M,M,M,F...; f_rdata equals RAM contents at f_addr=30.
- Reset asserted during WAIT of a read -> outputs go to 0 immediately, no done pulse follows; after release, a new m_req completes normally at k+4.
- m_req dropped one cycle after grant -> m_done still pulses once; with no new request, FSM stays in IDLE and ram_en stays 0.
